// File: rtl/cm162_pkg.sv
// cm162_pkg: shared constants and next-state/terminal-count helpers for the CM162 counter stage.
package cm162_pkg;
  localparam int CM162_MODULUS = 10;
  localparam int CM162_STAGE_W = 4;
  function automatic int unsigned cm162_next(input int unsigned q, input int unsigned modulus);
    return (q >= modulus - 1) ? 0 : q + 1;
  endfunction
  function automatic logic cm162_term(input int unsigned q, input int unsigned modulus);
    return q == modulus - 1;
  endfunction
endpackage

// File: rtl/cm162_stage.sv
// cm162_stage: one modulus digit register with clear/load/enable priority and ripple-carry out.
module cm162_stage
  import cm162_pkg::*;
#(
  parameter int MODULUS = CM162_MODULUS,
  parameter int STAGE_W = CM162_STAGE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_n,
  input  logic               load_n,
  input  logic               enp,
  input  logic               ent,
  input  logic [STAGE_W-1:0] data,
  output logic [STAGE_W-1:0] q,
  output logic               rco
);
  logic [STAGE_W-1:0] q_d, q_q;
  logic [STAGE_W-1:0] nxt;
  always_comb begin
    nxt = STAGE_W'(cm162_next(32'(q_q), int'(MODULUS)));
    q_d = !clr_n ? '0 : !load_n ? data : (enp && ent) ? nxt : q_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  // out-of-range states never match the terminal compare, so rco stays low for them
  assign rco = ent & cm162_term(32'(q_q), int'(MODULUS));
  assign q   = q_q;
endmodule

// File: rtl/cm162_counter_chain.sv
// cm162_counter_chain: N_STAGES cascaded CM162 digit stages forming one multi-digit counter.
module cm162_counter_chain
  import cm162_pkg::*;
#(
  parameter int MODULUS  = CM162_MODULUS,
  parameter int STAGE_W  = CM162_STAGE_W,
  parameter int N_STAGES = 2
) (
  input  logic                        clk_pad,
  input  logic                        rst_n_pad,
  input  logic                        clr_n_pad,
  input  logic                        load_n_pad,
  input  logic                        enp_pad,
  input  logic                        ent_pad,
  input  logic [N_STAGES*STAGE_W-1:0] data_pad,
  output logic [N_STAGES*STAGE_W-1:0] q_pad,
  output logic                        rco_pad
);
  if (MODULUS < 2 || MODULUS > 16) begin : g_bad_mod
    $error("cm162_counter_chain: MODULUS must be 2..16");
  end
  if ((1 << STAGE_W) < MODULUS) begin : g_bad_w
    $error("cm162_counter_chain: STAGE_W too narrow for MODULUS");
  end
  if (N_STAGES < 1 || N_STAGES > 8) begin : g_bad_n
    $error("cm162_counter_chain: N_STAGES must be 1..8");
  end
  logic [N_STAGES:0] ent;
  assign ent[0] = ent_pad;
  for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
    cm162_stage #(.MODULUS(MODULUS), .STAGE_W(STAGE_W)) u_stage (
      .clk   (clk_pad),
      .rst_n (rst_n_pad),
      .clr_n (clr_n_pad),
      .load_n(load_n_pad),
      .enp   (enp_pad),
      .ent   (ent[g]),
      .data  (data_pad[g*STAGE_W +: STAGE_W]),
      .q     (q_pad[g*STAGE_W +: STAGE_W]),
      .rco   (ent[g+1])
    );
  end
  assign rco_pad = ent[N_STAGES];
endmodule

// File: tb/tb_cm162_counter_chain.sv
// tb_cm162_counter_chain: directed and random checks of three counter configurations against a digit-array model.
module tb_cm162_counter_chain;
  typedef int dig_t[8];
  logic clk = 1'b0;
  logic rst_n, clr_n, load_n, enp, ent;
  logic [7:0] data0, q0;
  logic [3:0] data1, q1;
  logic [1:0] data2, q2;
  logic rco0, rco1, rco2;
  int n_chk = 0, n_pass = 0;
  dig_t md0 = '{default: 0}, md1 = '{default: 0}, md2 = '{default: 0};

  always #5 clk = ~clk;

  cm162_counter_chain u0 (.clk_pad(clk), .rst_n_pad(rst_n), .clr_n_pad(clr_n), .load_n_pad(load_n),
    .enp_pad(enp), .ent_pad(ent), .data_pad(data0), .q_pad(q0), .rco_pad(rco0));
  cm162_counter_chain #(.MODULUS(16), .STAGE_W(4), .N_STAGES(1)) u1 (.clk_pad(clk), .rst_n_pad(rst_n),
    .clr_n_pad(clr_n), .load_n_pad(load_n), .enp_pad(enp), .ent_pad(ent), .data_pad(data1),
    .q_pad(q1), .rco_pad(rco1));
  cm162_counter_chain #(.MODULUS(3), .STAGE_W(2), .N_STAGES(1)) u2 (.clk_pad(clk), .rst_n_pad(rst_n),
    .clr_n_pad(clr_n), .load_n_pad(load_n), .enp_pad(enp), .ent_pad(ent), .data_pad(data2),
    .q_pad(q2), .rco_pad(rco2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] pack(input dig_t d, input int w, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(d[k]) << (k * w));
    return v;
  endfunction

  function automatic dig_t unpack(input logic [31:0] v, input int w, input int n);
    dig_t d = '{default: 0};
    for (int k = 0; k < n; k++) d[k] = int'((v >> (k * w)) & ((32'd1 << w) - 1));
    return d;
  endfunction

  // in-range states count as one integer modulo m**n; out-of-range digits use the per-digit rule
  function automatic dig_t mstep(input dig_t d, input int m, input int n, input logic c_n,
                                 input logic l_n, input dig_t dat, input logic p, input logic t);
    dig_t r = d;
    int v = 0, pw = 1;
    bit inr = 1, low_term = 1;
    if (!c_n) r = '{default: 0};
    else if (!l_n) r = dat;
    else if (p && t) begin
      for (int k = 0; k < n; k++) inr = inr && (d[k] < m);
      if (inr) begin
        for (int k = 0; k < n; k++) begin v += d[k] * pw; pw *= m; end
        v = (v + 1) % pw;
        for (int k = 0; k < n; k++) begin r[k] = v % m; v /= m; end
      end else begin
        for (int k = 0; k < n; k++) begin
          if (low_term) r[k] = (d[k] >= m - 1) ? 0 : d[k] + 1;
          low_term = low_term && (d[k] == m - 1);
        end
      end
    end
    return r;
  endfunction

  function automatic logic mrco(input dig_t d, input int m, input int n, input logic t);
    logic all_term = t;
    for (int k = 0; k < n; k++) all_term = all_term && (d[k] == m - 1);
    return all_term;
  endfunction

  task automatic tick();
    @(posedge clk);
    md0 = mstep(md0, 10, 2, clr_n, load_n, unpack(32'(data0), 4, 2), enp, ent);
    md1 = mstep(md1, 16, 1, clr_n, load_n, unpack(32'(data1), 4, 1), enp, ent);
    md2 = mstep(md2, 3, 1, clr_n, load_n, unpack(32'(data2), 2, 1), enp, ent);
    #1;
    check("q0", 32'(q0), pack(md0, 4, 2));
    check("rco0", 32'(rco0), 32'(mrco(md0, 10, 2, ent)));
    check("q1", 32'(q1), pack(md1, 4, 1));
    check("rco1", 32'(rco1), 32'(mrco(md1, 16, 1, ent)));
    check("q2", 32'(q2), pack(md2, 2, 1));
    check("rco2", 32'(rco2), 32'(mrco(md2, 3, 1, ent)));
  endtask

  task automatic load(input logic [7:0] d0, input logic [3:0] d1, input logic [1:0] d2);
    data0 = d0; data1 = d1; data2 = d2; load_n = 1'b0;
    tick();
    load_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clr_n = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b0;
    data0 = '0; data1 = '0; data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", 32'(q0), 32'h00);
    check("reset_rco", 32'(rco0), 32'h0);
    rst_n = 1'b1;
    load(8'h47, 4'h7, 2'd1);
    check("load_47", 32'(q0), 32'h47);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", 32'(q0), 32'h00);
    check("async_rst_rco", 32'(rco0), 32'h0);
    md0 = '{default: 0}; md1 = '{default: 0}; md2 = '{default: 0};
    rst_n = 1'b1;
    enp = 1'b1; ent = 1'b1;
    repeat (99) tick();
    check("count_99", 32'(q0), 32'h99);
    check("count_99_rco", 32'(rco0), 32'h1);
    tick();
    check("wrap_00", 32'(q0), 32'h00);
    check("wrap_rco", 32'(rco0), 32'h0);
    enp = 1'b0; ent = 1'b0;
    load(8'h39, 4'h3, 2'd2);
    ent = 1'b1;
    tick();
    check("hold_39", 32'(q0), 32'h39);
    load(8'h99, 4'hF, 2'd2);
    tick();
    check("hold_99", 32'(q0), 32'h99);
    check("rco_enp0", 32'(rco0), 32'h1);
    ent = 1'b0;
    #1;
    check("rco_ent0", 32'(rco0), 32'h0);
    load(8'h58, 4'h5, 2'd1);
    check("load_58", 32'(q0), 32'h58);
    clr_n = 1'b0; load_n = 1'b0;
    tick();
    check("clr_wins", 32'(q0), 32'h00);
    clr_n = 1'b1;
    ent = 1'b1;
    load(8'h0C, 4'hC, 2'd3);
    check("load_0c", 32'(q0), 32'h0C);
    check("oor_rco", 32'(rco0), 32'h0);
    check("oor_rco2", 32'(rco2), 32'h0);
    enp = 1'b1;
    tick();
    check("oor_recover", 32'(q0), 32'h00);
    check("oor_recover_m3", 32'(q2), 32'h0);
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    tick();
    check("m3_seq1", 32'(q2), 32'h1);
    tick();
    check("m3_seq2", 32'(q2), 32'h2);
    check("m3_rco", 32'(rco2), 32'h1);
    tick();
    check("m3_seq0", 32'(q2), 32'h0);
    repeat (12) tick();
    check("m16_f", 32'(q1), 32'hF);
    check("m16_rco", 32'(rco1), 32'h1);
    tick();
    check("m16_wrap", 32'(q1), 32'h0);
    for (int i = 0; i < 400; i++) begin
      clr_n  = ($urandom_range(0, 19) != 0);
      load_n = ($urandom_range(0, 7) != 0);
      enp    = ($urandom_range(0, 3) != 0);
      ent    = ($urandom_range(0, 3) != 0);
      data0  = 8'($urandom);
      data1  = 4'($urandom);
      data2  = 2'($urandom);
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
